// File: rtl/nw_score_pkg.sv
// Shared Needleman-Wunsch Score-RAM definitions: neighbour tags, request
// modes, sequencer state encoding and the address-width helper.
package nw_score_pkg;

  localparam logic [1:0] TAG_DIAG = 2'b00;
  localparam logic [1:0] TAG_ROW  = 2'b01;
  localparam logic [1:0] TAG_COL  = 2'b10;

  localparam logic [1:0] MODE_FULL = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_WR   = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    WR
  } state_e;

  // Score matrix is (rows+1) x (cols+1) cells.
  function automatic int score_addr_w(input int rows, input int cols);
    return $clog2((rows + 1) * (cols + 1));
  endfunction

endpackage

// File: rtl/score_lin_addr.sv
// Combinational row-major linear address r*COLS + c, computed one bit wider
// than the result and truncated.
module score_lin_addr #(
  parameter int RW   = 3,
  parameter int CW   = 3,
  parameter int AW   = 5,
  parameter int COLS = 5
) (
  input  logic [RW-1:0] r_i,
  input  logic [CW-1:0] c_i,
  output logic [AW-1:0] addr_o
);
  logic [AW:0] r_ext;
  logic [AW:0] c_ext;
  logic [AW:0] cols_ext;

  assign r_ext    = (AW + 1)'(r_i);
  assign c_ext    = (AW + 1)'(c_i);
  assign cols_ext = (AW + 1)'(COLS);
  assign addr_o   = AW'(r_ext * cols_ext + c_ext);

endmodule

// File: rtl/score_addr_sequencer.sv
// Score-RAM address sequencer: per accepted cell it issues the diag, row and
// column neighbour reads in order, then the write of cell (i+1,j+1).
module score_addr_sequencer
  import nw_score_pkg::*;
#(
  parameter int N      = 128,
  parameter int M      = 128,
  parameter int IW     = $clog2(N + 1),
  parameter int JW     = $clog2(M + 1),
  parameter int ADDR_W = score_addr_w(N, M)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IW-1:0]     req_i,
  input  logic [JW-1:0]     req_j,
  input  logic [1:0]        req_mode,
  input  logic              hold,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [1:0]        rd_tag,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_valid,
  output logic              err,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d, eff_mode;
  logic [ADDR_W-1:0] base_q, base_d, req_base;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        rd_tag_q, rd_tag_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_valid_q, wr_valid_d;
  logic              err_q, err_d;
  logic              req_legal, is_last, accept;

  score_lin_addr #(
    .RW  (IW),
    .CW  (JW),
    .AW  (ADDR_W),
    .COLS(M + 1)
  ) u_lin (
    .r_i   (req_i),
    .c_i   (req_j),
    .addr_o(req_base)
  );

  assign req_legal = (req_i < IW'(N)) && (req_j < JW'(M));
  assign is_last   = (state_q == WR) || ((state_q == RD2) && (mode_q == MODE_RD));
  // Ready in the last issue state too, so back-to-back cells have no bubble.
  assign req_ready = !hold && ((state_q == IDLE) || is_last);
  assign accept    = req_valid && req_ready;
  assign eff_mode  = ((req_mode == MODE_WR) || (req_mode == MODE_RD)) ? req_mode : MODE_FULL;

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    base_d     = base_q;
    rd_addr_d  = rd_addr_q;
    rd_tag_d   = rd_tag_q;
    rd_valid_d = rd_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_valid_d = wr_valid_q;
    err_d      = 1'b0;
    if (!hold) begin
      case (state_q)
        RD0:     state_d = RD1;
        RD1:     state_d = RD2;
        RD2:     state_d = (mode_q == MODE_RD) ? IDLE : WR;
        default: state_d = IDLE;
      endcase
      if (accept) begin
        if (req_legal) begin
          base_d  = req_base;
          mode_d  = eff_mode;
          state_d = (eff_mode == MODE_WR) ? WR : RD0;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      // Outputs are decoded from the next state so they register with it.
      rd_valid_d = 1'b0;
      wr_valid_d = 1'b0;
      case (state_d)
        RD0: begin
          rd_valid_d = 1'b1;
          rd_addr_d  = base_d;
          rd_tag_d   = TAG_DIAG;
        end
        RD1: begin
          rd_valid_d = 1'b1;
          rd_addr_d  = base_d + ADDR_W'(1);
          rd_tag_d   = TAG_ROW;
        end
        RD2: begin
          rd_valid_d = 1'b1;
          rd_addr_d  = base_d + ADDR_W'(M + 1);
          rd_tag_d   = TAG_COL;
        end
        WR: begin
          wr_valid_d = 1'b1;
          wr_addr_d  = base_d + ADDR_W'(M + 2);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= MODE_FULL;
      base_q     <= '0;
      rd_addr_q  <= '0;
      rd_tag_q   <= TAG_DIAG;
      rd_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      base_q     <= base_d;
      rd_addr_q  <= rd_addr_d;
      rd_tag_q   <= rd_tag_d;
      rd_valid_q <= rd_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_valid_q <= wr_valid_d;
      err_q      <= err_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_tag   = rd_tag_q;
  assign rd_valid = rd_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_valid = wr_valid_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_score_addr_sequencer.sv
// Bench for score_addr_sequencer: a square (4x4) and a rectangular (4x6)
// instance share one stimulus stream; each has its own issue-list model.
module tb_score_addr_sequencer;
  import nw_score_pkg::*;

  localparam int N   = 4;
  localparam int M4  = 4;
  localparam int M6  = 6;
  localparam int AW4 = score_addr_w(N, M4);
  localparam int AW6 = score_addr_w(N, M6);

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid;
  logic           hold;
  logic [2:0]     req_i;
  logic [2:0]     req_j;
  logic [1:0]     req_mode;

  logic           rdy4, rv4, wv4, err4, busy4;
  logic [AW4-1:0] ra4, wa4;
  logic [1:0]     tag4;
  logic           rdy6, rv6, wv6, err6, busy6;
  logic [AW6-1:0] ra6, wa6;
  logic [1:0]     tag6;

  always #5 clk = ~clk;

  score_addr_sequencer #(.N(N), .M(M4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy4),
    .req_i(req_i), .req_j(req_j), .req_mode(req_mode), .hold(hold),
    .rd_addr(ra4), .rd_valid(rv4), .rd_tag(tag4), .wr_addr(wa4),
    .wr_valid(wv4), .err(err4), .busy(busy4)
  );

  score_addr_sequencer #(.N(N), .M(M6)) dut6 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy6),
    .req_i(req_i), .req_j(req_j), .req_mode(req_mode), .hold(hold),
    .rd_addr(ra6), .rd_valid(rv6), .rd_tag(tag6), .wr_addr(wa6),
    .wr_valid(wv6), .err(err6), .busy(busy6)
  );

  // Reference model: per instance, the list of issues still owed for the
  // current cell and the index of the one presented on the outputs now.
  typedef struct packed {
    logic        is_wr;
    logic [1:0]  tag;
    logic [31:0] addr;
  } item_t;

  item_t lst [2][5];
  int    n_it [2];
  int    pos [2];
  logic  err_m [2];
  int    cols [2];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input int k);
    return !hold && (pos[k] >= n_it[k] - 1);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      n_it[k]  = 0;
      pos[k]   = 0;
      err_m[k] = 1'b0;
    end
  endtask

  task automatic m_advance(input int k, input bit acc);
    int base;
    err_m[k] = 1'b0;
    if (!hold) begin
      if (acc) begin
        if ((int'(req_i) < N) && (int'(req_j) < cols[k] - 1)) begin
          base    = int'(req_i) * cols[k] + int'(req_j);
          n_it[k] = 0;
          if (req_mode != MODE_WR) begin
            lst[k][0] = '{1'b0, TAG_DIAG, 32'(base)};
            lst[k][1] = '{1'b0, TAG_ROW, 32'(base + 1)};
            lst[k][2] = '{1'b0, TAG_COL, 32'(base + cols[k])};
            n_it[k]   = 3;
          end
          if (req_mode != MODE_RD) begin
            lst[k][n_it[k]] = '{1'b1, 2'b00, 32'(base + cols[k] + 1)};
            n_it[k]         = n_it[k] + 1;
          end
        end else begin
          err_m[k] = 1'b1;
          n_it[k]  = 0;
        end
        pos[k] = 0;
      end else if (pos[k] < n_it[k]) begin
        pos[k] = pos[k] + 1;
      end
    end
  endtask

  task automatic chk_inst(input string nm, input int k, input logic rv, input logic wv,
                          input logic [31:0] ra, input logic [1:0] tg, input logic [31:0] wa,
                          input logic e, input logic b);
    bit    cur;
    item_t it;
    cur = pos[k] < n_it[k];
    it  = cur ? lst[k][pos[k]] : '0;
    chk({nm, ".rd_valid"}, rv, cur && !it.is_wr);
    chk({nm, ".wr_valid"}, wv, cur && it.is_wr);
    if (cur && !it.is_wr) begin
      chk({nm, ".rd_addr"}, ra, it.addr);
      chk({nm, ".rd_tag"}, tg, it.tag);
    end
    if (cur && it.is_wr) chk({nm, ".wr_addr"}, wa, it.addr);
    chk({nm, ".err"}, e, err_m[k]);
    chk({nm, ".busy"}, b, cur);
  endtask

  task automatic check_outputs();
    chk_inst("d4", 0, rv4, wv4, 32'(ra4), tag4, 32'(wa4), err4, busy4);
    chk_inst("d6", 1, rv6, wv6, 32'(ra6), tag6, 32'(wa6), err6, busy6);
  endtask

  // One clock: inputs already driven; starts and ends at a falling edge.
  task automatic cycle();
    bit acc [2];
    #1;
    for (int k = 0; k < 2; k++) acc[k] = req_valid && m_ready(k);
    chk("d4.req_ready", rdy4, m_ready(0));
    chk("d6.req_ready", rdy6, m_ready(1));
    @(posedge clk);
    for (int k = 0; k < 2; k++) m_advance(k, acc[k]);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    hold      = 1'b0;
    #1;
    chk("rst.d4.rd_addr", 32'(ra4), 0);
    chk("rst.d4.wr_addr", 32'(wa4), 0);
    chk("rst.d4.rd_tag", 32'(tag4), 0);
    chk("rst.d4.flags", {rv4, wv4, err4, busy4}, 0);
    chk("rst.d6.rd_addr", 32'(ra6), 0);
    chk("rst.d6.wr_addr", 32'(wa6), 0);
    chk("rst.d6.flags", {rv6, wv6, err6, busy6}, 0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic req(input int i, input int j, input logic [1:0] md);
    req_valid = 1'b1;
    req_i     = 3'(i);
    req_j     = 3'(j);
    req_mode  = md;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic idle_n(input int n);
    req_valid = 1'b0;
    hold      = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic wait_both_idle();
    for (int c = 0; c < 8 && (pos[0] < n_it[0] || pos[1] < n_it[1]); c++) idle_n(1);
  endtask

  initial begin
    cols[0]  = M4 + 1;
    cols[1]  = M6 + 1;
    req_i    = '0;
    req_j    = '0;
    req_mode = MODE_FULL;
    do_reset();

    req(0, 0, MODE_FULL);
    idle_n(4);

    req(3, 3, MODE_FULL);
    idle_n(3);
    req(1, 2, MODE_FULL);
    idle_n(4);

    req(2, 1, MODE_RD);
    idle_n(3);

    req(4, 0, MODE_FULL);
    idle_n(1);
    req(0, 4, MODE_FULL);
    idle_n(1);
    wait_both_idle();

    req(1, 1, MODE_FULL);
    idle_n(1);
    hold = 1'b1;
    repeat (3) cycle();
    idle_n(3);

    req(2, 2, MODE_FULL);
    idle_n(2);
    do_reset();
    req(0, 1, MODE_WR);
    idle_n(2);

    req(0, 0, 2'b11);
    idle_n(4);

    for (int n = 0; n < 600; n++) begin
      hold      = ($urandom_range(0, 4) == 0);
      req_valid = $urandom_range(0, 1) == 1;
      req_i     = 3'($urandom_range(0, 7));
      req_j     = 3'($urandom_range(0, 7));
      req_mode  = 2'($urandom_range(0, 3));
      cycle();
    end
    idle_n(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
